avalon_bidir_pio: RTL
=====================

Name: avalon_bidir_pio

Overview:
Parametrised Avalon-MM bidirectional parallel I/O port, WIDTH pins, each with its own direction bit. Successor to the single-bit SDA/SCL PIO used by the HDMI I2C bit-bang path. Adds:
- input synchronisation;
- open-drain mode for I2C-style buses;
- atomic set/clear of output bits;
- per-bit edge capture with a maskable interrupt.

Parameters:
WIDTH, 8, number of pins (1..32).
RESET_OUT, all ones, reset value of data_out register.
OPEN_DRAIN, 0, 1 = pins only pull low or release (Z), never drive high.
SYNC_STAGES, 2, input synchroniser depth (2..4).
EDGE_TYPE, 0, edge-capture trigger: 0 = rising, 1 = falling, 2 = any.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
address  in  3  register select
chipselect  in  1  Avalon slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits above WIDTH ignored
readdata  out  32  registered read data; bits above WIDTH are zero
irq  out  1  level interrupt
bidir_port  inout  WIDTH  external pins

Behaviour:
Reset: reset_n is asynchronous, active-low; clock is clk. All of the following reset asynchronously:
- data_out = RESET_OUT; dir = 0 (all inputs); irq_mask = 0; edge_cap = 0; readdata = 0; irq = 0.
- Synchroniser and previous-sample flops = 0.
- warm-up counter = SYNC_STAGES+1.

Register map (a write is chipselect & ~write_n):
- 0 DATA: read returns synchronised input (pin_sync); write loads data_out.
- 1 DIR: R/W; bit = 1 enables output.
- 2 IRQMASK: R/W.
- 3 EDGECAP: read returns edge_cap; write-1-to-clear per bit.
- 4 OUTSET: write sets data_out |= wd; reads 0.
- 5 OUTCLR: write clears data_out &= ~wd; reads 0.
- 6, 7: reserved; reads 0, writes ignored.

Read path:
- readdata is registered every clk from address, independent of chipselect.
- Latency 1 cycle.

Pin drive:
- OPEN_DRAIN = 0: pin[i] = dir[i] ? data_out[i] : Z.
- OPEN_DRAIN = 1: pin[i] = (dir[i] & ~data_out[i]) ? 0 : Z.

Input sampling:
- Pin value passes through SYNC_STAGES flops to give pin_sync.
- prev is pin_sync delayed by one clk.
- DATA read therefore reflects the pin SYNC_STAGES+1 cycles after the pin changes, including the readdata register.

Edge detect: rise = pin_sync & ~prev; fall = ~pin_sync & prev; selected by EDGE_TYPE.

Warm-up:
- Counter decrements each clk after reset until 0.
- edge_cap does not set while the counter is nonzero, which suppresses spurious edges from pins already high at reset.

edge_cap update per bit:
- Set on detected edge.
- Cleared by a 1 written to EDGECAP.
- Simultaneous set and clear on the same bit: set wins.

irq:
- irq = |(edge_cap & irq_mask), combinational from flops.
- Asserts the cycle after edge_cap sets, if the bit is masked in.

Simultaneous events:
- Only one register is written per cycle (single address).
- Writes to DIR take effect on the pin the cycle after the write.

Reset mid-operation: all pins return to Z immediately (dir = 0); pending edge_cap is lost; warm-up restarts.

Decomposition:
- Package avalon_pio_pkg holds:
  - address constants ADDR_DATA..ADDR_OUTCLR;
  - EDGE_RISE, EDGE_FALL, EDGE_ANY encodings;
  - the 32-bit readdata width constant.
- One sub-module, pio_sync_edge: WIDTH-bit synchroniser, previous-sample register, warm-up counter and edge detect. Outputs pin_sync and edge_pulse.

Test Plan:
1. Reset, no pins driven, pull-ups high → readdata 0; irq 0; after warm-up edge_cap stays 0; no spurious edge.
2. Write DIR = 0xFF, DATA = 0xA5 (OPEN_DRAIN = 0) → pins = 0xA5 one cycle after the DATA write. Then OUTSET 0x02 → 0xA7; then OUTCLR 0x80 → 0x27.
3. OPEN_DRAIN = 1, DIR = 0x01, DATA = 0x01 → pin0 = Z (external pull-up reads 1). DATA = 0x00 → pin0 = 0. Read DATA returns 0 after SYNC_STAGES+1 cycles.
4. EDGE_TYPE = 0, IRQMASK = 0x04, external pin2 driven 0→1 → edge_cap = 0x04 and irq = 1 within SYNC_STAGES+2 cycles. Write EDGECAP 0x04 → irq = 0 next cycle.
5. Rising edge on pin3 arriving in the same cycle as an EDGECAP write of 0x08 → bit3 stays 1 (set wins). Edge on masked-out pin5 → edge_cap bit5 = 1, irq stays 0.
6. Assert reset_n mid-drive with DIR = 0xFF → all pins Z asynchronously; all registers at reset values on the first read after deassertion.

Source files
------------

// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon bidirectional PIO.
// Register addresses, edge-select encodings and bus width.
package avalon_pio_pkg;

    localparam int RDATA_W = 32;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_bidir_pio_if.sv
// Avalon-MM slave bus of the bidirectional PIO.
// The host side uses master, the PIO uses slave.
interface avalon_bidir_pio_if;
    import avalon_pio_pkg::*;

    logic [2:0]         address;
    logic               chipselect;
    logic               write_n;
    logic [RDATA_W-1:0] writedata;
    logic [RDATA_W-1:0] readdata;
    logic               irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/pio_sync_edge.sv
// Pin synchroniser, previous sample, warm-up counter and edge detect.
// Edges are masked until the chain has flushed its reset zeros.
module pio_sync_edge
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_sync,
    output logic [WIDTH-1:0] edge_pulse
);

    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] WARM_INIT = CW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CW-1:0]    warm_q, warm_d;
    logic [WIDTH-1:0] rise, fall, edge_raw;

    assign pin_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
        prev_d = pin_sync;
        warm_d = warm_q;
        if (warm_q != '0)
            warm_d = warm_q - CW'(1);
        rise     = pin_sync & ~prev_q;
        fall     = ~pin_sync & prev_q;
        edge_raw = rise;
        case (EDGE_TYPE)
            EDGE_FALL: edge_raw = fall;
            EDGE_ANY:  edge_raw = rise | fall;
            default:   edge_raw = rise;
        endcase
        edge_pulse = (warm_q == '0) ? edge_raw : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
            warm_q <= WARM_INIT;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            warm_q <= warm_d;
        end
    end

endmodule

// File: rtl/avalon_bidir_pio.sv
// Avalon-MM bidirectional PIO with open-drain option,
// atomic set/clear and maskable per-bit edge capture.
module avalon_bidir_pio
    import avalon_pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_OUT   = '1,
    parameter int          OPEN_DRAIN  = 0,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_TYPE   = EDGE_RISE
) (
    input  logic               clk,
    input  logic               reset_n,
    avalon_bidir_pio_if.slave  bus,
    inout  wire  [WIDTH-1:0]   bidir_port
);

    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic [WIDTH-1:0]   dir_q, dir_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0]   cap_q, cap_d;
    logic [RDATA_W-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0]   pin_sync, edge_pulse;
    logic [WIDTH-1:0]   wd, oe, drv;
    logic               wr;
    logic               unused_wd;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .pin_in     (bidir_port),
        .pin_sync   (pin_sync),
        .edge_pulse (edge_pulse)
    );

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        cap_d      = cap_q;
        if (wr) begin
            unique case (bus.address)
                ADDR_DATA:    data_out_d = wd;
                ADDR_DIR:     dir_d      = wd;
                ADDR_IRQMASK: mask_d     = wd;
                ADDR_EDGECAP: cap_d      = cap_q & ~wd;
                ADDR_OUTSET:  data_out_d = data_out_q | wd;
                ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
                default:      ;
            endcase
        end
        // a new edge overrides a clear landing in the same cycle
        cap_d = cap_d | edge_pulse;
    end

    always_comb begin
        rdata_d = '0;
        unique case (bus.address)
            ADDR_DATA:    rdata_d[WIDTH-1:0] = pin_sync;
            ADDR_DIR:     rdata_d[WIDTH-1:0] = dir_q;
            ADDR_IRQMASK: rdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: rdata_d[WIDTH-1:0] = cap_q;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_OUT[WIDTH-1:0];
            dir_q      <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            rdata_q    <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign bus.irq      = |(cap_q & mask_q);

    if (OPEN_DRAIN != 0) begin : g_od
        assign oe  = dir_q & ~data_out_q;
        assign drv = '0;
    end else begin : g_pp
        assign oe  = dir_q;
        assign drv = data_out_q;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = oe[i] ? drv[i] : 1'bz;
    end

endmodule
